// File: rtl/vmv_pkg.sv
// rtl/vmv_pkg.sv - shared types and helpers for the element-wise vector multiplier
package vmv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} vmv_state_e;

    // Widest element the reduction helper supports; products are handled at twice this.
    localparam int MAX_W = 64;
    localparam int PROD_W = 2 * MAX_W;

    // Number of chunks needed to cover n elements, d at a time.
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Reduces a sign-extended product to a width-bit signed value.
    // Returns {overflow, value}; value is meaningful in its low width bits.
    function automatic logic [MAX_W:0] sat_trunc(input logic signed [PROD_W-1:0] prod,
                                                 input logic sat_en,
                                                 input int width);
        logic signed [PROD_W-1:0] one;
        logic signed [PROD_W-1:0] max_v;
        logic signed [PROD_W-1:0] min_v;
        logic signed [PROD_W-1:0] val;
        logic                     ovf;
        one   = {{(PROD_W-1){1'b0}}, 1'b1};
        max_v = (one <<< (width - 1)) - one;
        min_v = -max_v - one;
        ovf   = (prod > max_v) || (prod < min_v);
        val   = prod;
        if (sat_en && ovf) begin
            val = prod[PROD_W-1] ? min_v : max_v;
        end
        return {ovf, val[MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/vmv_lane.sv
// rtl/vmv_lane.sv - one lane: stage1 constant divide, stage2 multiply and reduce
module vmv_lane
    import vmv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIV_A = 50000000,
    parameter int DIV_B = 43
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_el_i,
    input  logic [WIDTH-1:0] b_el_i,
    input  logic             sat_en_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] res_el_o,
    output logic             ovf_el_o
);

    localparam logic signed [WIDTH-1:0] DIV_A_S = WIDTH'(DIV_A);
    localparam logic signed [WIDTH-1:0] DIV_B_S = WIDTH'(DIV_B);

    logic                      s1_vld_q;
    logic                      s1_sat_q;
    logic signed [WIDTH-1:0]   qa_q, qb_q;
    logic signed [WIDTH-1:0]   qa_d, qb_d;
    logic signed [2*WIDTH-1:0] prod;
    logic [MAX_W:0]            red;
    logic                      s2_vld_q;
    logic [WIDTH-1:0]          res_q;
    logic                      ovf_q;

    // Signed division truncates toward zero, which is the required rounding.
    assign qa_d = $signed(a_el_i) / DIV_A_S;
    assign qb_d = $signed(b_el_i) / DIV_B_S;
    assign prod = qa_q * qb_q;
    assign red  = sat_trunc(PROD_W'(prod), s1_sat_q, WIDTH);

    // Stage1: register the pre-scaled operands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q <= 1'b0;
            s1_sat_q <= 1'b0;
            qa_q     <= '0;
            qb_q     <= '0;
        end else begin
            s1_vld_q <= valid_i;
            s1_sat_q <= sat_en_i;
            qa_q     <= qa_d;
            qb_q     <= qb_d;
        end
    end

    // Stage2: register the reduced product; overflow only counts for a valid element.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_vld_q <= 1'b0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            res_q    <= red[WIDTH-1:0];
            ovf_q    <= s1_vld_q & red[MAX_W];
        end
    end

    assign valid_o  = s2_vld_q;
    assign res_el_o = res_q;
    assign ovf_el_o = ovf_q;

endmodule

// File: rtl/vector_mul_vector_seq.sv
// rtl/vector_mul_vector_seq.sv - chunked element-wise vector multiply with pre-scaling
module vector_mul_vector_seq
    import vmv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int VEC_LEN = 5,
    parameter int LANES   = 1,
    parameter int DIV_A   = 50000000,
    parameter int DIV_B   = 43
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [VEC_LEN-1:0][WIDTH-1:0]   a,
    input  logic [VEC_LEN-1:0][WIDTH-1:0]   b,
    input  logic                            sat_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [VEC_LEN-1:0][WIDTH-1:0]   result,
    output logic                            ovf
);

    localparam int NCHUNK = ceil_div(VEC_LEN, LANES);
    localparam int CW     = $clog2(NCHUNK + 1);

    vmv_state_e                    state_q;
    logic                          in_ready_q, out_valid_q, ovf_q;
    logic [VEC_LEN-1:0][WIDTH-1:0] a_q, b_q, result_q;
    logic                          sat_q;
    logic [CW-1:0]                 chunk_q;
    logic                          tag1_vld_q, tag2_vld_q;
    logic [CW-1:0]                 tag1_q, tag2_q;

    logic                          issue;
    logic                          last_wb;
    logic [LANES-1:0]              lane_vld_in, lane_vld_out, lane_ovf;
    logic [LANES-1:0][WIDTH-1:0]   lane_a, lane_b, lane_res;
    logic [VEC_LEN-1:0]            res_we;
    logic [VEC_LEN-1:0][WIDTH-1:0] res_d;

    assign issue   = (state_q == RUN) && (chunk_q < CW'(NCHUNK));
    assign last_wb = tag2_vld_q && (tag2_q == CW'(NCHUNK - 1));

    // Route the elements of the current chunk onto the lanes; lanes past VEC_LEN stay idle.
    always_comb begin
        lane_a      = '0;
        lane_b      = '0;
        lane_vld_in = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (chunk_q == CW'(i / LANES)) begin
                lane_a[i % LANES]      = a_q[i];
                lane_b[i % LANES]      = b_q[i];
                lane_vld_in[i % LANES] = issue;
            end
        end
    end

    // Map lane outputs of the chunk leaving stage2 back onto result elements.
    always_comb begin
        res_we = '0;
        res_d  = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            res_we[i] = tag2_vld_q && (tag2_q == CW'(i / LANES)) && lane_vld_out[i % LANES];
            res_d[i]  = lane_res[i % LANES];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vmv_lane #(
            .WIDTH (WIDTH),
            .DIV_A (DIV_A),
            .DIV_B (DIV_B)
        ) u_lane (
            .clk_i    (clk),
            .rst_i    (rst),
            .valid_i  (lane_vld_in[l]),
            .a_el_i   (lane_a[l]),
            .b_el_i   (lane_b[l]),
            .sat_en_i (sat_q),
            .valid_o  (lane_vld_out[l]),
            .res_el_o (lane_res[l]),
            .ovf_el_o (lane_ovf[l])
        );
    end

    // Control FSM with chunk tags tracking the two-stage lane pipeline and result write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sat_q       <= 1'b0;
            chunk_q     <= '0;
            tag1_vld_q  <= 1'b0;
            tag2_vld_q  <= 1'b0;
            tag1_q      <= '0;
            tag2_q      <= '0;
        end else begin
            tag1_vld_q <= issue;
            tag1_q     <= chunk_q;
            tag2_vld_q <= tag1_vld_q;
            tag2_q     <= tag1_q;
            for (int i = 0; i < VEC_LEN; i++) begin
                if (res_we[i]) begin
                    result_q[i] <= res_d[i];
                end
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        sat_q      <= sat_en;
                        ovf_q      <= 1'b0;
                        chunk_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        chunk_q <= chunk_q + CW'(1);
                    end
                    ovf_q <= ovf_q | (|lane_ovf);
                    if (last_wb) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_vector_mul_vector_seq.sv
// tb/tb_vector_mul_vector_seq.sv - directed bench for vector_mul_vector_seq
module tb_vector_mul_vector_seq;

    typedef logic [4:0][31:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, sat_en, out_ready;
    vec_t a, b;
    logic in_ready0, out_valid0, ovf0;
    logic in_ready1, out_valid1, ovf1;
    logic in_ready2, out_valid2, ovf2;
    vec_t result0, result1, result2;

    int total = 0, passed = 0, failed = 0;
    int lat0, lat1, lat2;
    vec_t r0, r1, r2;
    logic o0, o1, o2;
    vec_t exp_v;
    logic stable;
    int   c;

    vector_mul_vector_seq u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .sat_en(sat_en), .out_valid(out_valid0),
        .out_ready(out_ready), .result(result0), .ovf(ovf0)
    );

    vector_mul_vector_seq #(.DIV_A(1), .DIV_B(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .sat_en(sat_en), .out_valid(out_valid1),
        .out_ready(out_ready), .result(result1), .ovf(ovf1)
    );

    vector_mul_vector_seq #(.LANES(2), .DIV_A(1), .DIV_B(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .sat_en(sat_en), .out_valid(out_valid2),
        .out_ready(out_ready), .result(result2), .ovf(ovf2)
    );

    function automatic vec_t fill(input logic [31:0] v);
        vec_t r;
        for (int i = 0; i < 5; i++) r[i] = v;
        return r;
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle in_valid pulse, then record latency/result/ovf of each instance.
    task automatic run_vec();
        lat0 = 0; lat1 = 0; lat2 = 0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 40 && (lat0 == 0 || lat1 == 0 || lat2 == 0); k++) begin
            @(negedge clk);
            if (out_valid0 && lat0 == 0) begin lat0 = k; r0 = result0; o0 = ovf0; end
            if (out_valid1 && lat1 == 0) begin lat1 = k; r1 = result1; o1 = ovf1; end
            if (out_valid2 && lat2 == 0) begin lat2 = k; r2 = result2; o2 = ovf2; end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sat_en = 1'b0; out_ready = 1'b1;
        a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {in_ready0, in_ready1, in_ready2}, 3'b111);
        check("rst_out_valid", out_valid0, 1'b0);
        check("rst_ovf", ovf0, 1'b0);
        check("rst_result", result0, '0);
        rst = 1'b0;
        @(negedge clk);

        // Scaling with default divisors; DIV=1 instances overflow and clamp.
        a = fill(32'd100000000); b = fill(32'd86); sat_en = 1'b1;
        run_vec();
        check("scale_lat", lat0, 7);
        check("scale_res", r0, fill(32'd4));
        check("scale_ovf", o0, 1'b0);
        check("div1_lat", lat1, 7);
        check("div1_res", r1, fill(32'h7FFFFFFF));
        check("div1_ovf", o1, 1'b1);
        check("lanes2_sat_lat", lat2, 5);

        // Negative operands and truncation toward zero.
        a[0] = -32'sd150000000; b[0] = 32'sd129;
        a[1] = 32'sd49999999;   b[1] = 32'sd43;
        a[2] = -32'sd49999999;  b[2] = -32'sd43;
        a[3] = 32'sd0;          b[3] = 32'sd0;
        a[4] = 32'sd2147483647; b[4] = 32'h80000000;
        sat_en = 1'b0;
        run_vec();
        exp_v[0] = -32'sd9; exp_v[1] = '0; exp_v[2] = '0; exp_v[3] = '0;
        exp_v[4] = -32'sd2097542160;
        check("trunc_res", r0, exp_v);
        check("trunc_ovf", o0, 1'b0);

        // Overflow with saturation, both directions.
        a = '0; b = '0;
        a[0] = 32'h40000000; b[0] = 32'd4;
        a[1] = 32'hC0000000; b[1] = 32'd4;
        sat_en = 1'b1;
        run_vec();
        exp_v = '0; exp_v[0] = 32'h7FFFFFFF; exp_v[1] = 32'h80000000;
        check("sat_res", r1, exp_v);
        check("sat_ovf", o1, 1'b1);
        check("sat_res_l2", r2, exp_v);
        check("sat_ovf_l2", o2, 1'b1);

        // Same overflow with wrap.
        sat_en = 1'b0;
        run_vec();
        check("wrap_res", r1, '0);
        check("wrap_ovf", o1, 1'b1);

        // Following vector without overflow clears the flag.
        a = fill(32'd3); b = fill(32'd7);
        run_vec();
        check("noovf_res", r1, fill(32'd21));
        check("noovf_ovf", o1, 1'b0);

        // Two lanes, masked sixth lane.
        for (int i = 0; i < 5; i++) a[i] = 32'(i + 1);
        b = fill(32'd10);
        sat_en = 1'b1;
        run_vec();
        exp_v[0] = 32'd10; exp_v[1] = 32'd20; exp_v[2] = 32'd30;
        exp_v[3] = 32'd40; exp_v[4] = 32'd50;
        check("lanes_lat", lat2, 5);
        check("lanes_res", r2, exp_v);
        check("lanes_ovf", o2, 1'b0);
        check("lanes_res_l1", r1, exp_v);

        // Backpressure on the default instance.
        a[0] = 32'd100000000;  b[0] = 32'd86;
        a[1] = 32'd150000000;  b[1] = 32'd43;
        a[2] = -32'sd100000000; b[2] = 32'd43;
        a[3] = 32'd50000000;   b[3] = 32'd430;
        a[4] = 32'd0;          b[4] = 32'd5;
        exp_v[0] = 32'd4; exp_v[1] = 32'd3; exp_v[2] = -32'sd2;
        exp_v[3] = 32'd10; exp_v[4] = 32'd0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        c = 0;
        for (int k = 1; k <= 40 && c == 0; k++) begin
            @(negedge clk);
            if (out_valid0) c = k;
        end
        check("bp_lat", c, 7);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            a = fill(32'd500000000);
            @(negedge clk);
            if (!(out_valid0 === 1'b1 && in_ready0 === 1'b0 &&
                  result0 === exp_v && ovf0 === 1'b0)) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_stable", stable, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready0, 1'b1);
        check("bp_release_valid", out_valid0, 1'b0);
        check("bp_release_res", result0, exp_v);
        @(negedge clk);

        // Reset in the middle of RUN.
        a = fill(32'd100000000); b = fill(32'd86); sat_en = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", in_ready0, 1'b1);
        check("midrst_valid", out_valid0, 1'b0);
        check("midrst_res", result0, '0);
        rst = 1'b0;
        @(negedge clk);
        a = fill(32'd250000000); b = fill(32'd129);
        run_vec();
        check("after_rst_lat", lat0, 7);
        check("after_rst_res", r0, fill(32'd15));
        check("after_rst_ovf", o0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
